// File: rtl/multicycle_control.sv
// Multi-cycle control unit for the RV32I datapath.
// Accepts one instruction through a valid/ready handshake, latches it, and
// sequences it through DECODE/EXEC/MEM/WB while driving the datapath control
// strobes for each phase. Unsupported encodings are flagged, MEM holds while
// data memory stalls, and completed instructions are counted.
//
// Ports:
//   clk, rst        rising-edge clock, synchronous active-high reset
//   instr_in        instruction word offered by fetch
//   instr_valid     instr_in is valid
//   instr_ready     unit can accept (IDLE and not in reset)
//   mem_ready       data memory completes its access this cycle
//   instruction     latched instruction for the datapath
//   RegWrite        register-file write enable (WB only, never for rd=x0)
//   ALUSrc          ALU B operand: 0 = rs2, 1 = immediate
//   ALUop           ALU operation select
//   MemWrite        data-memory write strobe (MEM of SW)
//   MemRead         data-memory read enable (MEM of LW)
//   MemtoReg        writeback source: 1 = memory, 0 = ALU
//   done            one-cycle pulse in the final cycle of a legal instruction
//   illegal         one-cycle pulse when decode rejects the instruction
//   retired         count of done pulses, wraps modulo 2^CNT_W
module multicycle_control #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      instr_in,
  input  logic             instr_valid,
  output logic             instr_ready,
  input  logic             mem_ready,
  output logic [31:0]      instruction,
  output logic             RegWrite,
  output logic             ALUSrc,
  output logic [3:0]       ALUop,
  output logic             MemWrite,
  output logic             MemRead,
  output logic             MemtoReg,
  output logic             done,
  output logic             illegal,
  output logic [CNT_W-1:0] retired
);

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] F7_BASE  = 7'b0000000;
  localparam logic [6:0] F7_ALT   = 7'b0100000;
  localparam logic [2:0] F3_WORD  = 3'b010;

  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_XOR  = 4'b0011;
  localparam logic [3:0] ALU_SLL  = 4'b0100;
  localparam logic [3:0] ALU_SRL  = 4'b0101;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_SLT  = 4'b0111;
  localparam logic [3:0] ALU_SRA  = 4'b1000;
  localparam logic [3:0] ALU_SLTU = 4'b1001;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4
  } stateT;

  stateT state, stateNext;

  // funct3 -> ALU op; alt selects SUB/SRA (funct7 bit 5)
  function automatic logic [3:0] aluFromFunct3(input logic [2:0] f3, input logic alt);
    logic [3:0] op;
    case (f3)
      3'b000:  op = alt ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

  // Decode looks at the offered word while IDLE (so illegal can be
  // registered at the accept edge) and at the latched word afterwards.
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       rdNonZero;
  logic       decLegal;
  logic       decLoad;
  logic       decStore;
  logic       decAluSrc;
  logic [3:0] decAluOp;

  always_comb begin
    opcode    = (state == IDLE) ? instr_in[6:0]   : instruction[6:0];
    funct3    = (state == IDLE) ? instr_in[14:12] : instruction[14:12];
    funct7    = (state == IDLE) ? instr_in[31:25] : instruction[31:25];
    rdNonZero = (instruction[11:7] != 5'd0);
    decLegal  = 1'b0;
    decLoad   = 1'b0;
    decStore  = 1'b0;
    decAluSrc = 1'b0;
    decAluOp  = ALU_AND;
    case (opcode)
      OP_R: begin
        decAluOp = aluFromFunct3(funct3, funct7[5]);
        decLegal = (funct7 == F7_BASE) ||
                   ((funct7 == F7_ALT) && ((funct3 == 3'b000) || (funct3 == 3'b101)));
      end
      OP_I: begin
        decAluSrc = 1'b1;
        // bit 30 is immediate data except for the right shifts
        decAluOp  = aluFromFunct3(funct3, (funct3 == 3'b101) && funct7[5]);
        case (funct3)
          3'b001:  decLegal = (funct7 == F7_BASE);
          3'b101:  decLegal = (funct7 == F7_BASE) || (funct7 == F7_ALT);
          default: decLegal = 1'b1;
        endcase
      end
      OP_LOAD: begin
        decAluSrc = 1'b1;
        decAluOp  = ALU_ADD;
        decLoad   = 1'b1;
        decLegal  = (funct3 == F3_WORD);
      end
      OP_STORE: begin
        decAluSrc = 1'b1;
        decAluOp  = ALU_ADD;
        decStore  = 1'b1;
        decLegal  = (funct3 == F3_WORD);
      end
      default: decLegal = 1'b0;
    endcase
  end

  // Next-state and next-output values; outputs are registered so each
  // value below describes the state being entered.
  logic [31:0] instrNext;
  logic        regWriteNext;
  logic        aluSrcNext;
  logic [3:0]  aluOpNext;
  logic        memWriteNext;
  logic        memReadNext;
  logic        memtoRegNext;
  logic        wbDoneNext;
  logic        illegalNext;

  always_comb begin
    stateNext    = state;
    instrNext    = instruction;
    regWriteNext = 1'b0;
    aluSrcNext   = 1'b0;
    aluOpNext    = ALU_AND;
    memWriteNext = 1'b0;
    memReadNext  = 1'b0;
    memtoRegNext = 1'b0;
    wbDoneNext   = 1'b0;
    illegalNext  = 1'b0;
    case (state)
      IDLE: begin
        if (instr_valid) begin
          instrNext   = instr_in;
          stateNext   = DECODE;
          illegalNext = !decLegal;
        end
      end
      DECODE: begin
        if (decLegal) begin
          stateNext  = EXEC;
          aluSrcNext = decAluSrc;
          aluOpNext  = decAluOp;
        end else begin
          stateNext = IDLE;
        end
      end
      EXEC: begin
        aluSrcNext = decAluSrc;
        aluOpNext  = decAluOp;
        if (decLoad || decStore) begin
          stateNext    = MEM;
          memReadNext  = decLoad;
          memWriteNext = decStore;
        end else begin
          stateNext    = WB;
          regWriteNext = rdNonZero;
          wbDoneNext   = 1'b1;
        end
      end
      MEM: begin
        if (mem_ready) begin
          if (decLoad) begin
            stateNext    = WB;
            aluSrcNext   = decAluSrc;
            aluOpNext    = decAluOp;
            regWriteNext = rdNonZero;
            memtoRegNext = 1'b1;
            wbDoneNext   = 1'b1;
          end else begin
            stateNext = IDLE;
          end
        end else begin
          aluSrcNext   = decAluSrc;
          aluOpNext    = decAluOp;
          memReadNext  = decLoad;
          memWriteNext = decStore;
        end
      end
      WB: begin
        stateNext = IDLE;
      end
      default: begin
        stateNext = IDLE;
      end
    endcase
  end

  logic wbDone;

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      instruction <= 32'd0;
      RegWrite    <= 1'b0;
      ALUSrc      <= 1'b0;
      ALUop       <= ALU_AND;
      MemWrite    <= 1'b0;
      MemRead     <= 1'b0;
      MemtoReg    <= 1'b0;
      wbDone      <= 1'b0;
      illegal     <= 1'b0;
    end else begin
      state       <= stateNext;
      instruction <= instrNext;
      RegWrite    <= regWriteNext;
      ALUSrc      <= aluSrcNext;
      ALUop       <= aluOpNext;
      MemWrite    <= memWriteNext;
      MemRead     <= memReadNext;
      MemtoReg    <= memtoRegNext;
      wbDone      <= wbDoneNext;
      illegal     <= illegalNext;
    end
  end

  // A store finishes in whichever MEM cycle memory accepts it, which is not
  // known a cycle ahead, so its done term follows mem_ready directly.
  assign done        = wbDone || ((state == MEM) && decStore && mem_ready && !rst);
  assign instr_ready = (state == IDLE) && !rst;

  // Retired-instruction counter
  always_ff @(posedge clk) begin
    if (rst) begin
      retired <= '0;
    end else if (done) begin
      retired <= retired + CNT_W'(1);
    end
  end

endmodule
